// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout score path.
package breakout_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PEND_W  = 6;
   localparam int unsigned LIVES_W = 3;

   typedef logic [DIGIT_W-1:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE,
      C10,
      C100,
      C1000
   } state_t;

   typedef struct packed {
      bcd_t d1000;
      bcd_t d100;
      bcd_t d10;
      bcd_t d1;
   } score_t;

   localparam bcd_t               MAX_DIGIT   = 4'd9;
   localparam logic [PEND_W-1:0]  PENDING_MAX = 6'd63;

   // Brick points above 9 count as 9.
   function automatic bcd_t clamp_points(input logic [DIGIT_W-1:0] p);
      return (p > MAX_DIGIT) ? MAX_DIGIT : p;
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-logic events in, score/lives status out to the stats renderer.
interface score_keeper_if;
   import breakout_pkg::*;

   logic                NEW_GAME;
   logic                BRICK_HIT;
   logic [DIGIT_W-1:0]  BRICK_POINTS;
   logic                BALL_LOST;
   bcd_t                SCORE_1000;
   bcd_t                SCORE_100;
   bcd_t                SCORE_10;
   bcd_t                SCORE_1;
   logic [LIVES_W-1:0]  LIVES;
   logic                GAME_OVER;
   logic                BUSY;

   modport master (
      output NEW_GAME, BRICK_HIT, BRICK_POINTS, BALL_LOST,
      input  SCORE_1000, SCORE_100, SCORE_10, SCORE_1, LIVES, GAME_OVER, BUSY
   );

   modport slave (
      input  NEW_GAME, BRICK_HIT, BRICK_POINTS, BALL_LOST,
      output SCORE_1000, SCORE_100, SCORE_10, SCORE_1, LIVES, GAME_OVER, BUSY
   );

endinterface

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: digit + addend (0..9) with decimal carry out.
module bcd_digit_add
   import breakout_pkg::*;
(
   input  bcd_t               digit,
   input  logic [DIGIT_W-1:0] addend,
   output bcd_t               sum,
   output logic               carry
);

   localparam int unsigned RAW_W = DIGIT_W + 1;

   logic [RAW_W-1:0] raw;

   always_comb begin
      raw   = RAW_W'(digit) + RAW_W'(addend);
      carry = (raw > RAW_W'(MAX_DIGIT));
      sum   = carry ? DIGIT_W'(raw - RAW_W'(10)) : DIGIT_W'(raw);
   end

endmodule

// File: rtl/score_keeper.sv
// Accumulates brick points into a saturating 4-digit BCD score, one digit per
// cycle, and tracks lives, bonus lives and game over.
module score_keeper
   import breakout_pkg::*;
#(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned MAX_LIVES     = 7,
   parameter bit          EXTRA_LIFE_EN = 1'b1
) (
   input logic           CLK,
   input logic           RESET_N,
   score_keeper_if.slave sk
);

   localparam int unsigned        SUM_W     = PEND_W + 1;
   localparam logic [LIVES_W-1:0] START_L   = LIVES_W'(START_LIVES);
   localparam logic [LIVES_W-1:0] MAX_L     = LIVES_W'(MAX_LIVES);
   localparam score_t             ALL_NINES = score_t'({4{MAX_DIGIT}});

   state_t             state_q, state_d;
   score_t             score_q, score_d;
   logic [PEND_W-1:0]  pend_q, pend_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               over_q, over_d;
   logic               busy_q, busy_d;

   logic [SUM_W-1:0]   pend_sum;
   bcd_t               hit_pts, chunk, step_in, ones_sum, step_sum;
   logic               ones_c, step_c, bonus, lost;

   bcd_digit_add u_ones (
      .digit  (score_q.d1),
      .addend (chunk),
      .sum    (ones_sum),
      .carry  (ones_c)
   );

   bcd_digit_add u_step (
      .digit  (step_in),
      .addend (DIGIT_W'(1)),
      .sum    (step_sum),
      .carry  (step_c)
   );

   // Operand selection for the carry-step adder and the ones-digit chunk.
   always_comb begin
      hit_pts = (sk.BRICK_HIT && !over_q) ? clamp_points(sk.BRICK_POINTS) : '0;
      chunk   = (pend_q > PEND_W'(MAX_DIGIT)) ? MAX_DIGIT : DIGIT_W'(pend_q);
      case (state_q)
         C10:     step_in = score_q.d10;
         C100:    step_in = score_q.d100;
         C1000:   step_in = score_q.d1000;
         default: step_in = score_q.d10;
      endcase
   end

   // Next-state, score, pending and lives update.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      lives_d  = lives_q;
      over_d   = over_q;
      bonus    = 1'b0;
      pend_sum = SUM_W'(pend_q) + SUM_W'(hit_pts);

      case (state_q)
         IDLE: begin
            if (pend_q != '0) begin
               if (score_q == ALL_NINES) begin
                  pend_sum = '0;
               end else begin
                  pend_sum   = SUM_W'(pend_q) - SUM_W'(chunk) + SUM_W'(hit_pts);
                  score_d.d1 = ones_sum;
                  if (ones_c) state_d = C10;
               end
            end
         end
         C10: begin
            score_d.d10 = step_sum;
            state_d     = step_c ? C100 : IDLE;
         end
         C100: begin
            score_d.d100 = step_sum;
            state_d      = step_c ? C1000 : IDLE;
         end
         C1000: begin
            state_d = IDLE;
            if (step_c) begin
               // Thousands overflow: hold at 9999 and drop outstanding points.
               score_d  = ALL_NINES;
               pend_sum = '0;
            end else begin
               score_d.d1000 = step_sum;
               bonus         = EXTRA_LIFE_EN && !over_q && (lives_q < MAX_L);
            end
         end
         default: state_d = IDLE;
      endcase

      pend_d  = (pend_sum > SUM_W'(PENDING_MAX)) ? PENDING_MAX : PEND_W'(pend_sum);
      lost    = sk.BALL_LOST && (lives_q != '0);
      lives_d = lives_q + LIVES_W'(bonus) - LIVES_W'(lost);
      over_d  = over_q || (lives_d == '0);

      if (sk.NEW_GAME) begin
         state_d = IDLE;
         score_d = '0;
         pend_d  = '0;
         lives_d = START_L;
         over_d  = 1'b0;
      end

      busy_d = (state_d != IDLE) || (pend_d != '0);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         score_q <= '0;
         pend_q  <= '0;
         lives_q <= START_L;
         over_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         pend_q  <= pend_d;
         lives_q <= lives_d;
         over_q  <= over_d;
         busy_q  <= busy_d;
      end
   end

   assign sk.SCORE_1000 = score_q.d1000;
   assign sk.SCORE_100  = score_q.d100;
   assign sk.SCORE_10   = score_q.d10;
   assign sk.SCORE_1    = score_q.d1;
   assign sk.LIVES      = lives_q;
   assign sk.GAME_OVER  = over_q;
   assign sk.BUSY       = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected scores queued at stimulus time.
`timescale 1ns/1ps
module tb_score_keeper;
   import breakout_pkg::*;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;

   score_keeper_if sk ();

   score_keeper #(
      .START_LIVES   (3),
      .MAX_LIVES     (7),
      .EXTRA_LIFE_EN (1'b1)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .sk      (sk)
   );

   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad = 0;
   int          m_score = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dut_score();
      return {sk.SCORE_1000, sk.SCORE_100, sk.SCORE_10, sk.SCORE_1};
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic valid_bcd(input logic [15:0] s);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
         if (s[i*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) check("sb_empty", 16'd1, 16'd0);
      else check(tag, dut_score(), exp_q.pop_front());
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sk.BUSY && n < 40) begin
         step();
         n++;
      end
      if (sk.BUSY) check("idle_timeout", 16'(sk.BUSY), 16'd0);
   endtask

   task automatic hit(input int p);
      sk.BRICK_HIT    = 1'b1;
      sk.BRICK_POINTS = 4'(p);
      step();
      sk.BRICK_HIT    = 1'b0;
      sk.BRICK_POINTS = 4'd0;
   endtask

   task automatic pulse_lost();
      sk.BALL_LOST = 1'b1;
      step();
      sk.BALL_LOST = 1'b0;
   endtask

   task automatic new_game();
      sk.NEW_GAME = 1'b1;
      step();
      sk.NEW_GAME = 1'b0;
      m_score = 0;
   endtask

   // Adds n points as a series of hits; the model score saturates at 9999.
   task automatic add_points(input int n, input string tag);
      int left, p;
      left = n;
      m_score = (m_score + n > 9999) ? 9999 : m_score + n;
      exp_q.push_back(to_bcd(m_score));
      while (left > 0) begin
         p = (left > 9) ? 9 : left;
         hit(p);
         wait_idle();
         left -= p;
      end
      pop_check(tag);
   endtask

   initial begin
      logic bad_digit;
      int   n;
      sk.NEW_GAME = 1'b0;
      sk.BRICK_HIT = 1'b0;
      sk.BRICK_POINTS = 4'd0;
      sk.BALL_LOST = 1'b0;
      repeat (3) step();
      RESET_N = 1'b1;
      step();

      check("rst_score", dut_score(), 16'h0000);
      check("rst_lives", 16'(sk.LIVES), 16'd3);
      check("rst_over", 16'(sk.GAME_OVER), 16'd0);
      check("rst_busy", 16'(sk.BUSY), 16'd0);

      // Single hit of 7: ones digit at E+1, idle by E+2
      exp_q.push_back(to_bcd(7));
      hit(7);
      step();
      pop_check("hit7_e1");
      step();
      check("hit7_busy", 16'(sk.BUSY), 16'd0);
      m_score = 7;

      // Carry chain 0999 + 1
      add_points(992, "to_0999");
      exp_q.push_back(16'h0990);
      exp_q.push_back(16'h0900);
      exp_q.push_back(16'h1000);
      hit(1);
      step();
      pop_check("carry_e1");
      step();
      pop_check("carry_e2");
      n = 0;
      step();
      while (sk.SCORE_1000 == 4'd0 && n < 3) begin
         step();
         n++;
      end
      pop_check("carry_final");
      m_score = 1000;
      check("bonus_lives", 16'(sk.LIVES), 16'd4);
      check("carry_busy", 16'(sk.BUSY), 16'd0);

      // Climb to lives 7 via thousands steps
      add_points(1000, "to_2000");
      check("lives_2000", 16'(sk.LIVES), 16'd5);
      add_points(1000, "to_3000");
      add_points(1000, "to_4000");
      check("lives_4000", 16'(sk.LIVES), 16'd7);
      add_points(999, "to_4999");

      // Ball lost on the thousands-step edge with LIVES at max
      exp_q.push_back(16'h5000);
      hit(1);
      n = 0;
      while (dut_score() != 16'h4000 && n < 6) begin
         step();
         n++;
      end
      check("reach_4000", dut_score(), 16'h4000);
      pulse_lost();
      pop_check("score_5000");
      check("lives_max_lost", 16'(sk.LIVES), 16'd6);
      m_score = 5000;

      // NEW_GAME while in C100
      add_points(99, "to_5099");
      exp_q.push_back(16'h5090);
      exp_q.push_back(16'h5000);
      hit(1);
      step();
      pop_check("mid_e1");
      step();
      pop_check("mid_e2");
      new_game();
      check("ng_score", dut_score(), 16'h0000);
      check("ng_busy", 16'(sk.BUSY), 16'd0);
      check("ng_lives", 16'(sk.LIVES), 16'd3);
      step();
      check("ng_settled", dut_score(), 16'h0000);

      // Four back-to-back hits of 9
      bad_digit = 1'b0;
      m_score = 36;
      exp_q.push_back(to_bcd(36));
      sk.BRICK_HIT = 1'b1;
      sk.BRICK_POINTS = 4'd9;
      for (int i = 0; i < 4; i++) begin
         step();
         if (!valid_bcd(dut_score())) bad_digit = 1'b1;
      end
      sk.BRICK_HIT = 1'b0;
      sk.BRICK_POINTS = 4'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!valid_bcd(dut_score())) bad_digit = 1'b1;
      end
      wait_idle();
      check("b2b_valid", 16'(bad_digit), 16'd0);
      pop_check("b2b_0036");

      // Saturation at 9999
      add_points(9959, "to_9995");
      check("lives_9995", 16'(sk.LIVES), 16'd7);
      pulse_lost();
      check("lives_lost6", 16'(sk.LIVES), 16'd6);
      add_points(9, "sat_9999");
      check("sat_no_bonus", 16'(sk.LIVES), 16'd6);
      add_points(5, "sat_hold");
      check("sat_busy", 16'(sk.BUSY), 16'd0);

      // Lives to zero, game over, hits ignored, restart
      new_game();
      add_points(12, "to_0012");
      pulse_lost();
      pulse_lost();
      check("lives_1", 16'(sk.LIVES), 16'd1);
      check("over_pre", 16'(sk.GAME_OVER), 16'd0);
      pulse_lost();
      check("lives_0", 16'(sk.LIVES), 16'd0);
      check("over_set", 16'(sk.GAME_OVER), 16'd1);
      pulse_lost();
      check("lives_0_hold", 16'(sk.LIVES), 16'd0);
      exp_q.push_back(16'h0012);
      hit(4);
      check("over_busy", 16'(sk.BUSY), 16'd0);
      step();
      pop_check("over_hit_ignored");
      new_game();
      check("restart_score", dut_score(), 16'h0000);
      check("restart_lives", 16'(sk.LIVES), 16'd3);
      check("restart_over", 16'(sk.GAME_OVER), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
